// File: rtl/sram_like_pkg.sv
// Shared sram-like bus widths and helpers used by the arbiter and its ID FIFO.
package sram_like_pkg;
    localparam int SRAM_ADDR_W = 32;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_SIZE_W = 2;
    localparam int SRAM_STRB_W = 4;

    typedef enum logic {
        LK_IDLE,
        LK_HELD
    } lock_state_t;

    function automatic int slice_off(input int ch, input int w);
        return ch * w;
    endfunction
endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of channel IDs for accepted-but-unanswered transactions.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
endmodule

// File: rtl/sram_like_arbiter.sv
// Merges NUM_CH sram-like masters onto one slave port and routes responses back in order.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = 0,
    localparam int CW     = $clog2(NUM_CH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_CH-1:0]             m_req,
    input  logic [NUM_CH-1:0]             m_wr,
    input  logic [SRAM_SIZE_W*NUM_CH-1:0] m_size,
    input  logic [SRAM_STRB_W*NUM_CH-1:0] m_wstrb,
    input  logic [SRAM_ADDR_W*NUM_CH-1:0] m_addr,
    input  logic [SRAM_DATA_W*NUM_CH-1:0] m_wdata,
    output logic [NUM_CH-1:0]             m_addr_ok,
    output logic [NUM_CH-1:0]             m_data_ok,
    output logic [SRAM_DATA_W-1:0]        m_rdata,
    output logic                          s_req,
    output logic                          s_wr,
    output logic [SRAM_SIZE_W-1:0]        s_size,
    output logic [SRAM_STRB_W-1:0]        s_wstrb,
    output logic [SRAM_ADDR_W-1:0]        s_addr,
    output logic [SRAM_DATA_W-1:0]        s_wdata,
    input  logic                          s_addr_ok,
    input  logic                          s_data_ok,
    input  logic [SRAM_DATA_W-1:0]        s_rdata,
    output logic [CNT_W-1:0]              pend_cnt,
    output logic                          err
);
    // Handshake: a request transfers in the cycle where req and addr_ok are both high;
    // the matching data_ok arrives later, in request order, and carries rdata.

    lock_state_t lock_state, lock_next;
    logic [CW-1:0] locked_ch, locked_ch_next;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] arb_ch;
    logic [CW-1:0] grant;
    logic [CW-1:0] head;
    logic          full, empty, accept, bypass, push, pop, found;
    int            idx;

    always_comb begin
        arb_ch = '0;
        found  = 1'b0;
        idx    = 0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_req[i]) arb_ch = CW'(i);
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (!found && m_req[idx]) begin
                    arb_ch = CW'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    // A stalled request keeps its channel so the slave sees stable fields.
    assign grant  = (lock_state == LK_HELD) ? locked_ch : arb_ch;
    assign s_req  = (|m_req) & ~full;
    assign accept = s_req & s_addr_ok;
    assign bypass = accept & s_data_ok & empty;
    assign push   = accept & ~bypass;
    assign pop    = s_data_ok & ~empty;

    assign s_wr    = m_wr[grant];
    assign s_size  = m_size[slice_off(int'(grant), SRAM_SIZE_W) +: SRAM_SIZE_W];
    assign s_wstrb = m_wstrb[slice_off(int'(grant), SRAM_STRB_W) +: SRAM_STRB_W];
    assign s_addr  = m_addr[slice_off(int'(grant), SRAM_ADDR_W) +: SRAM_ADDR_W];
    assign s_wdata = m_wdata[slice_off(int'(grant), SRAM_DATA_W) +: SRAM_DATA_W];
    assign m_rdata = s_rdata;

    always_comb begin
        lock_next      = lock_state;
        locked_ch_next = locked_ch;
        m_addr_ok      = '0;
        m_data_ok      = '0;
        case (lock_state)
            LK_IDLE: if (s_req && !s_addr_ok) begin
                lock_next      = LK_HELD;
                locked_ch_next = grant;
            end
            LK_HELD: if (s_addr_ok) lock_next = LK_IDLE;
            default: lock_next = LK_IDLE;
        endcase
        if (accept) m_addr_ok[grant] = 1'b1;
        if (pop) begin
            m_data_ok[head] = 1'b1;
        end else if (bypass) begin
            m_data_ok[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_state <= LK_IDLE;
            locked_ch  <= '0;
            rr_ptr     <= '0;
            err        <= 1'b0;
        end else begin
            lock_state <= lock_next;
            locked_ch  <= locked_ch_next;
            if (RR_MODE != 0 && accept) begin
                rr_ptr <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
            if (s_data_ok && empty && !accept) err <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (DEPTH),
        .W     (CW),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  (grant),
        .head   (head),
        .empty  (empty),
        .full   (full),
        .count  (pend_cnt)
    );
endmodule
